mdu_core: RTL and testbench
===========================

MDU_CORE -- requirements
Module: mdu_core

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand, HI and LO width in bits (legal range 8..64).
REQ-002 The block SHALL have parameter MUL_CYCLES, default 5, giving the busy duration in cycles of all multiply-class ops (legal range 1..16).
REQ-003 The block SHALL have parameter DIV_CYCLES, default 10, giving the busy duration in cycles of all divide-class ops (legal range 1..64).
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port start, input, 1 bit: request to launch the op on op/a/b this cycle.
REQ-007 Port op, input, 4 bits: operation select, encoded 0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu, 6 msub, 7 msubu, 8..15 reserved.
REQ-008 Port a, input, WIDTH bits: first operand (dividend for divides).
REQ-009 Port b, input, WIDTH bits: second operand (divisor for divides).
REQ-010 Port hi_we, input, 1 bit: direct write of wdata into HI (mthi).
REQ-011 Port lo_we, input, 1 bit: direct write of wdata into LO (mtlo).
REQ-012 Port wdata, input, WIDTH bits: data for direct HI/LO writes.
REQ-013 Port busy, output, 1 bit, registered: an operation is in progress.
REQ-014 Port done, output, 1 bit, registered: one-cycle pulse marking the cycle in which the new HI/LO values first appear.
REQ-015 Port hi, output, WIDTH bits: HI register contents.
REQ-016 Port lo, output, WIDTH bits: LO register contents.

Function
REQ-017 States SHALL be IDLE and RUN; a cycle counter SHALL be wide enough to hold max(MUL_CYCLES, DIV_CYCLES).
REQ-018 In IDLE, start=1 with op in 0..7 SHALL latch op, a, b and the current HI/LO on that edge, enter RUN, set busy=1 and load the counter with the op-class latency L.
REQ-019 In IDLE, start=1 with a reserved op SHALL be ignored: no state change, busy stays 0, hi/lo unchanged.
REQ-020 In RUN the counter SHALL decrement once per edge; on the L-th edge after the start edge, hi/lo SHALL update, busy SHALL drop to 0, done SHALL go to 1 for exactly one cycle, and the state SHALL return to IDLE.
REQ-021 start, hi_we and lo_we SHALL be ignored while busy=1; the pipeline stalls on start|busy.
REQ-022 In IDLE, if start is accepted, hi_we/lo_we in the same cycle SHALL be dropped; otherwise hi_we loads HI and lo_we loads LO from wdata, and both may fire together.
REQ-023 mult/multu SHALL set {HI,LO} to the full 2*WIDTH-bit signed/unsigned product of a and b.
REQ-024 madd/maddu SHALL set {HI,LO} to the latched {HI,LO} plus the signed/unsigned product, modulo 2^(2*WIDTH).
REQ-025 msub/msubu SHALL set {HI,LO} to the latched {HI,LO} minus the signed/unsigned product, modulo 2^(2*WIDTH).
REQ-026 div SHALL set LO to the signed quotient truncated toward zero and HI to the remainder, which takes the sign of the dividend.
REQ-027 divu SHALL set LO to the unsigned quotient and HI to the unsigned remainder.
REQ-028 For div/divu with b=0, HI and LO SHALL remain unchanged, with the full DIV_CYCLES busy period and a done pulse.
REQ-029 For div with a=most-negative and b=-1, LO SHALL be the most-negative value and HI SHALL be 0.
REQ-030 The result SHALL depend only on the values latched at the start edge; input changes during RUN SHALL have no effect.
REQ-031 start accepted in the cycle of a done pulse SHALL launch normally, since the state is already IDLE; this allows back-to-back operations with no gap cycle.

Reset
REQ-032 reset=1 SHALL immediately force state IDLE, counter 0, busy=0, done=0, hi=0, lo=0, regardless of clk.
REQ-033 Reset asserted during RUN SHALL abort the operation with no HI/LO update and no done pulse.

Verification
REQ-034 Scenario 1: WIDTH=32; mult a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
REQ-035 Scenario 2: mthi 0, mtlo 10; madd a=2, b=2 -> lo=14, hi=0; then msubu a=5, b=3 -> lo=0xFFFFFFFF, hi=0xFFFFFFFF.
REQ-036 Scenario 3: div a=-7, b=2 -> after 10 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); divu a=7, b=0 -> hi/lo unchanged, done pulses.
REQ-037 Scenario 4: during busy, pulse start with op=0 and hi_we with wdata=0x55 -> both ignored, final result is that of the first op only.
REQ-038 Scenario 5: assert reset at the 3rd busy cycle of multu a=b=0xFFFFFFFF -> busy=0, hi=lo=0 at once, no done pulse.
REQ-039 Scenario 6: WIDTH=16, MUL_CYCLES=1; multu a=0xFFFF, b=0xFFFF -> one busy cycle, then hi=0xFFFE, lo=0x0001.

Source files
------------

// File: rtl/mdu_core.sv
// Multiply/divide unit with HI/LO accumulator registers.
// Fixed-latency multi-cycle ops; results computed from operands latched at launch.
module mdu_core #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;

    logic [2*WIDTH-1:0] w_uprod;
    logic [2*WIDTH-1:0] w_sprod;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_res;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_mq;
    logic [WIDTH-1:0]   w_mr;
    logic [WIDTH-1:0]   w_squo;
    logic [WIDTH-1:0]   w_srem;
    logic [WIDTH-1:0]   w_uquo;
    logic [WIDTH-1:0]   w_urem;
    logic               w_accept;
    logic               w_is_div;
    logic               w_div_zero;

    assign w_uprod = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
    assign w_sprod = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_prod  = r_op[0] ? w_uprod : w_sprod;
    assign w_acc   = {r_hi, r_lo};

    // Signed divide via magnitudes; most-negative / -1 wraps back to most-negative.
    assign w_abs_a = r_a[WIDTH-1] ? -r_a : r_a;
    assign w_abs_b = r_b[WIDTH-1] ? -r_b : r_b;
    assign w_mq    = w_abs_a / w_abs_b;
    assign w_mr    = w_abs_a % w_abs_b;
    assign w_squo  = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? -w_mq : w_mq;
    assign w_srem  = r_a[WIDTH-1] ? -w_mr : w_mr;
    assign w_uquo  = r_a / r_b;
    assign w_urem  = r_a % r_b;

    assign w_accept   = start && !op[3];
    assign w_is_div   = (r_op[2:1] == 2'b01);
    assign w_div_zero = w_is_div && (r_b == '0);

    always_comb begin
        w_res = w_acc;
        case (r_op)
            3'd0, 3'd1: w_res = w_prod;
            3'd2:       w_res = {w_srem, w_squo};
            3'd3:       w_res = {w_urem, w_uquo};
            3'd4, 3'd5: w_res = w_acc + w_prod;
            default:    w_res = w_acc - w_prod;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= op[2:0];
                        r_a     <= a;
                        r_b     <= b;
                        r_cnt   <= (op[2:1] == 2'b01) ? CW'(DIV_CYCLES)
                                                      : CW'(MUL_CYCLES);
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
                end
                RUN: begin
                    if (r_cnt == CW'(1)) begin
                        if (!w_div_zero) {r_hi, r_lo} <= w_res;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_core.sv
// Directed bench for mdu_core: per-cycle reference-model compare plus literal checks.
// Covers mult/madd/msub/div families, stalls, reserved ops, async reset, WIDTH=16.
module tb_mdu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, hi_we0, lo_we0;
    logic [3:0]  op0;
    logic [31:0] a0, b0, wdata0;
    logic        busy0, done0;
    logic [31:0] hi0, lo0;

    logic        start1;
    logic [3:0]  op1;
    logic [15:0] a1, b1;
    logic        busy1, done1;
    logic [15:0] hi1, lo1;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    always #5 clk = ~clk;

    mdu_core u_dut (
        .clk(clk), .reset(rst), .start(start0), .op(op0),
        .a(a0), .b(b0), .hi_we(hi_we0), .lo_we(lo_we0), .wdata(wdata0),
        .busy(busy0), .done(done0), .hi(hi0), .lo(lo0)
    );

    mdu_core #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) u_w16 (
        .clk(clk), .reset(rst), .start(start1), .op(op1),
        .a(a1), .b(b1), .hi_we(1'b0), .lo_we(1'b0), .wdata(16'h0),
        .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
    );

    // Reference model: arithmetic straight from the op definitions.
    function automatic logic [64:0] ref_op(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [63:0] acc);
        logic [63:0] ps, pu, p;
        int sa, sb, q, r;
        ps = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        pu = {32'h0, a} * {32'h0, b};
        p  = op[0] ? pu : ps;
        case (op)
            4'd0, 4'd1: return {1'b1, p};
            4'd4, 4'd5: return {1'b1, acc + p};
            4'd6, 4'd7: return {1'b1, acc - p};
            4'd2: begin
                if (b == 0) return {1'b0, acc};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return {1'b1, 32'h0, 32'h8000_0000};
                sa = a;
                sb = b;
                q  = sa / sb;
                r  = sa % sb;
                return {1'b1, 32'(r), 32'(q)};
            end
            4'd3: begin
                if (b == 0) return {1'b0, acc};
                return {1'b1, a % b, a / b};
            end
            default: return {1'b0, acc};
        endcase
    endfunction

    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    bit          m_upd, m_pend, m_done;
    int          cyc, m_fin;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi   = '0;
            m_lo   = '0;
            m_pend = 0;
            m_done = 0;
        end else begin
            cyc++;
            m_done = 0;
            if (m_pend) begin
                if (cyc == m_fin) begin
                    m_pend = 0;
                    m_done = 1;
                    if (m_upd) {m_hi, m_lo} = m_res;
                end
            end else if (start0 && op0 < 8) begin
                m_pend = 1;
                m_fin  = cyc + ((op0 == 2 || op0 == 3) ? 10 : 5);
                {m_upd, m_res} = ref_op(op0, a0, b0, {m_hi, m_lo});
            end else begin
                if (hi_we0) m_hi = wdata0;
                if (lo_we0) m_lo = wdata0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (busy0 !== m_pend || done0 !== m_done ||
                hi0 !== m_hi || lo0 !== m_lo) begin
                failures++;
                $display("FAIL model cyc=%0d busy=%b/%b done=%b/%b hi=%h/%h lo=%h/%h",
                         cyc, busy0, m_pend, done0, m_done, hi0, m_hi, lo0, m_lo);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        start0 = 1'b1;
        op0    = op;
        a0     = a;
        b0     = b;
        tick();
        start0 = 1'b0;
    endtask

    task automatic wait_done(output int nb);
        bit seen;
        nb   = 0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done0) seen = 1;
            else if (busy0) nb++;
        end
        if (!seen) begin
            failures++;
            $display("FAIL done_timeout got=none want=pulse");
        end
    endtask

    int nb, nd;

    initial begin
        rst = 1'b1;
        start0 = 0; hi_we0 = 0; lo_we0 = 0; op0 = 0;
        a0 = 0; b0 = 0; wdata0 = 0;
        start1 = 0; op1 = 0; a1 = 0; b1 = 0;
        #1 chk_en = 1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_hi", hi0, 0);
        chk("rst_lo", lo0, 0);

        // Scenario 1: signed mult
        do_op(4'd0, 32'hFFFF_FFFE, 32'd3);
        wait_done(nb);
        chk("s1_lat", nb, 5);
        chk("s1_hi", hi0, 32'hFFFF_FFFF);
        chk("s1_lo", lo0, 32'hFFFF_FFFA);

        // Scenario 2: mthi/mtlo, madd, msubu
        hi_we0 = 1; wdata0 = 0;
        tick();
        hi_we0 = 0; lo_we0 = 1; wdata0 = 10;
        tick();
        lo_we0 = 0;
        do_op(4'd4, 32'd2, 32'd2);
        wait_done(nb);
        chk("s2_madd_hi", hi0, 0);
        chk("s2_madd_lo", lo0, 14);
        do_op(4'd7, 32'd5, 32'd3);
        wait_done(nb);
        chk("s2_msubu", {hi0, lo0}, 64'hFFFF_FFFF_FFFF_FFFF);

        // Scenario 3: signed div, divu by zero
        do_op(4'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(nb);
        chk("s3_lat", nb, 10);
        chk("s3_lo", lo0, 32'hFFFF_FFFD);
        chk("s3_hi", hi0, 32'hFFFF_FFFF);
        do_op(4'd3, 32'd7, 32'd0);
        wait_done(nb);
        chk("s3_dz_lat", nb, 10);
        chk("s3_dz", {hi0, lo0}, 64'hFFFF_FFFF_FFFF_FFFD);

        do_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(nb);
        chk("ovf_div", {hi0, lo0}, 64'h0000_0000_8000_0000);

        // Signed multiply-subtract and unsigned multiply-add chain
        do_op(4'd0, 32'd3, 32'hFFFF_FFFC);
        wait_done(nb);
        do_op(4'd6, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        wait_done(nb);
        chk("msub", {hi0, lo0}, 64'hFFFF_FFFF_FFFF_FFEE);
        do_op(4'd5, 32'hFFFF_FFFF, 32'd2);
        wait_done(nb);
        chk("maddu", {hi0, lo0}, 64'h0000_0001_FFFF_FFEC);

        // Scenario 4: start and mthi while busy are ignored
        do_op(4'd1, 32'd3, 32'd4);
        start0 = 1; op0 = 0; a0 = 100; b0 = 100;
        hi_we0 = 1; wdata0 = 32'h55;
        tick();
        start0 = 0; hi_we0 = 0;
        wait_done(nb);
        chk("s4_stall", {hi0, lo0}, 64'd12);

        // Reserved op ignored; same-cycle mthi still applies
        tick();
        start0 = 1; op0 = 4'd9; a0 = 1; b0 = 1;
        hi_we0 = 1; wdata0 = 32'hABCD;
        tick();
        start0 = 0; hi_we0 = 0;
        @(negedge clk);
        chk("rsv_busy", busy0, 0);
        chk("rsv_hi", hi0, 32'hABCD);

        // Accepted start drops a same-cycle mtlo
        lo_we0 = 1; wdata0 = 32'h77;
        do_op(4'd1, 32'd2, 32'd2);
        lo_we0 = 0;
        wait_done(nb);
        chk("drop_we", {hi0, lo0}, 64'd4);

        // Scenario 6: WIDTH=16, single-cycle multiply
        start1 = 1; op1 = 4'd1; a1 = 16'hFFFF; b1 = 16'hFFFF;
        tick();
        start1 = 0;
        @(negedge clk);
        chk("s6_busy", {busy1, done1}, 2'b10);
        @(negedge clk);
        chk("s6_done", {busy1, done1}, 2'b01);
        chk("s6_res", {hi1, lo1}, 32'hFFFE_0001);

        // Scenario 5: async reset at the 3rd busy cycle
        do_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("s5_busy", busy0, 0);
        chk("s5_hilo", {hi0, lo0}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done0) nd++;
        end
        chk("s5_nodone", nd, 0);

        do_op(4'd0, 32'd2, 32'd3);
        wait_done(nb);
        chk("post_rst", {hi0, lo0}, 64'd6);

        tick();
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
